frv_asi_issue: RTL and testbench

Issue/retire sequencer for the algorithm-specific instruction (ASI) unit: the initiator side of the ASI handshake. It accepts one decoded ASI operation from the execute stage, registers its operands, and drives `asi_valid`, `asi_uop`, `asi_rs1`, `asi_rs2` and `asi_shamt` stably until `asi_ready`. It captures `asi_result` and presents it to writeback on a valid/ready channel. It also owns flush propagation and a no-response watchdog.

---
 rtl/frv_asi_issue_if.sv | 24 ++
 rtl/frv_asi_issue.sv | 141 ++++++++++++++
 tb/tb_frv_asi_issue.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frv_asi_issue_if.sv
// ASI handshake bundle between the issue sequencer (master) and the ASI unit (slave).
interface frv_asi_issue_if #(
  parameter int XLEN = 32,
  parameter int UOPW = 5
);
  logic            asi_valid;
  logic            asi_flush;
  logic            asi_ready;
  logic [UOPW-1:0] asi_uop;
  logic [XLEN-1:0] asi_rs1;
  logic [XLEN-1:0] asi_rs2;
  logic [1:0]      asi_shamt;
  logic [XLEN-1:0] asi_result;

  modport master (
    output asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2, asi_shamt,
    input  asi_ready, asi_result
  );

  modport slave (
    input  asi_valid, asi_flush, asi_uop, asi_rs1, asi_rs2, asi_shamt,
    output asi_ready, asi_result
  );
endinterface

// File: rtl/frv_asi_issue.sv
// ASI issue/retire sequencer: registers one operation, holds it on the ASI bus until
// asi_ready (or watchdog timeout), then presents the result to writeback.
module frv_asi_issue #(
  parameter int XLEN     = 32,
  parameter int UOPW     = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [UOPW-1:0]     s_uop,
  input  logic [XLEN-1:0]     s_rs1,
  input  logic [XLEN-1:0]     s_rs2,
  input  logic [1:0]          s_shamt,
  input  logic [4:0]          s_rd,
  frv_asi_issue_if.master     asi,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [4:0]          m_rd,
  output logic [XLEN-1:0]     m_result,
  output logic                m_err
);

  localparam int WW = $clog2(MAX_WAIT) + 1;
  localparam logic [WW-1:0] WLAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [UOPW-1:0] uop_q, uop_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [1:0]      shamt_q, shamt_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;

  logic in_exec, xfer, timeout;

  always_comb begin
    in_exec = (state_q == EXEC);
    s_ready = !flush && ((state_q == IDLE) || ((state_q == HOLD) && m_ready));
    xfer    = s_valid && s_ready;
    timeout = in_exec && !flush && !asi.asi_ready && (wcnt_q == WLAST);
  end

  // Operands are zeroed outside EXEC so the ASI datapaths see no toggling.
  always_comb begin
    asi.asi_valid = in_exec;
    asi.asi_flush = in_exec && (flush || timeout);
    asi.asi_uop   = in_exec ? uop_q   : '0;
    asi.asi_rs1   = in_exec ? rs1_q   : '0;
    asi.asi_rs2   = in_exec ? rs2_q   : '0;
    asi.asi_shamt = in_exec ? shamt_q : '0;
    m_valid       = (state_q == HOLD);
    m_rd          = rd_q;
    m_result      = result_q;
    m_err         = err_q;
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    uop_d    = uop_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    shamt_d  = shamt_q;
    rd_d     = rd_q;
    result_d = result_q;
    err_d    = err_q;

    // xfer already excludes flush, so capture is shared by IDLE and HOLD.
    if (xfer) begin
      uop_d   = s_uop;
      rs1_d   = s_rs1;
      rs2_d   = s_rs2;
      shamt_d = s_shamt;
      rd_d    = s_rd;
      wcnt_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (xfer) state_d = EXEC;
      end
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (asi.asi_ready) begin
          result_d = asi.asi_result;
          err_d    = 1'b0;
          state_d  = HOLD;
        end else if (timeout) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = HOLD;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (flush)        state_d = IDLE;
        else if (xfer)    state_d = EXEC;
        else if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      uop_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      shamt_q  <= '0;
      rd_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      uop_q    <= uop_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      shamt_q  <= shamt_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_frv_asi_issue.sv
// Directed bench for frv_asi_issue with a behavioural ASI stub (latency L, result rs1^rs2).
module tb_frv_asi_issue;

  localparam int XLEN = 32;
  localparam int UOPW = 5;
  localparam int MAX_WAIT = 16;
  localparam logic [4:0] UOP_SHA256_S0 = 5'd2;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] res;
    logic            err;
  } exp_t;

  logic            g_clk = 1'b0;
  logic            g_resetn;
  logic            flush;
  logic            s_valid;
  logic            s_ready;
  logic [UOPW-1:0] s_uop;
  logic [XLEN-1:0] s_rs1, s_rs2;
  logic [1:0]      s_shamt;
  logic [4:0]      s_rd;
  logic            m_valid;
  logic            m_ready;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_result;
  logic            m_err;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int unsigned stub_lat;
  int unsigned stub_cnt;

  frv_asi_issue_if #(.XLEN(XLEN), .UOPW(UOPW)) aif ();

  frv_asi_issue #(.XLEN(XLEN), .UOPW(UOPW), .MAX_WAIT(MAX_WAIT)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_uop(s_uop), .s_rs1(s_rs1),
    .s_rs2(s_rs2), .s_shamt(s_shamt), .s_rd(s_rd),
    .asi(aif.master),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd),
    .m_result(m_result), .m_err(m_err)
  );

  always #5 g_clk = ~g_clk;

  // ASI stub: ready in the L-th valid cycle of an operation; L=0 never answers.
  assign aif.asi_ready  = aif.asi_valid && (stub_lat != 0) && (stub_cnt == stub_lat - 1);
  assign aif.asi_result = aif.asi_rs1 ^ aif.asi_rs2;

  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) stub_cnt <= 0;
    else if (aif.asi_valid && !aif.asi_ready && !aif.asi_flush) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge g_clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge g_clk);
  endtask

  task automatic drive_op(input logic [4:0] uop, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [1:0] sh, input logic [4:0] rd, input bit expect_result);
    s_valid = 1'b1;
    s_uop   = uop;
    s_rs1   = r1;
    s_rs2   = r2;
    s_shamt = sh;
    s_rd    = rd;
    if (expect_result) sb.push_back('{rd: rd, res: r1 ^ r2, err: 1'b0});
  endtask

  // Retire monitor: a handshake at this negedge completes on the next posedge.
  always @(negedge g_clk) begin
    if (g_resetn && m_valid && m_ready && !flush) begin
      chk("sb_nonempty_at_retire", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("m_rd", m_rd, e.rd);
        chk("m_result", m_result, e.res);
        chk("m_err", m_err, e.err);
      end
    end
  end

  initial begin
    g_resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_uop = '0; s_rs1 = '0;
    s_rs2 = '0; s_shamt = '0; s_rd = '0; m_ready = 1'b1; stub_lat = 1;

    // Reset values, before any clock edge
    #3;
    chk("rst_asi_valid", aif.asi_valid, 0);
    chk("rst_asi_flush", aif.asi_flush, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_ready", s_ready, 1);
    flush = 1'b1; #1;
    chk("rst_s_ready_flush", s_ready, 0);
    flush = 1'b0; #1;
    chk("rst_s_ready_noflush", s_ready, 1);
    #2 g_resetn = 1'b1;
    to_drive();

    // 1. Single-cycle op
    drive_op(UOP_SHA256_S0, 32'h12345678, 32'h0F0F0F0F, 2'd1, 5'd5, 1'b1);
    to_sample(); chk("t1_s_ready_idle", s_ready, 1);
    to_drive();  s_valid = 1'b0;
    to_sample();
    chk("t1_asi_valid_c1", aif.asi_valid, 1);
    chk("t1_asi_uop", aif.asi_uop, UOP_SHA256_S0);
    chk("t1_asi_rs1", aif.asi_rs1, 32'h12345678);
    chk("t1_asi_rs2", aif.asi_rs2, 32'h0F0F0F0F);
    chk("t1_asi_shamt", aif.asi_shamt, 2'd1);
    chk("t1_m_valid_c1", m_valid, 0);
    chk("t1_s_ready_exec", s_ready, 0);
    to_drive(); to_sample();
    chk("t1_asi_valid_c2", aif.asi_valid, 0);
    chk("t1_m_valid_c2", m_valid, 1);
    chk("t1_m_result_lit", m_result, 32'h1D3B5977);
    chk("t1_asi_rs1_zero", aif.asi_rs1, 0);
    chk("t1_asi_uop_zero", aif.asi_uop, 0);
    to_drive(); to_sample();
    chk("t1_m_valid_c3", m_valid, 0);

    // 2. Stall: L=4, writeback stalls 3 cycles
    to_drive();
    stub_lat = 4; m_ready = 1'b0;
    drive_op(5'd7, 32'hCAFEBABE, 32'h01234567, 2'd3, 5'd12, 1'b1);
    to_sample(); chk("t2_s_ready_idle", s_ready, 1);
    to_drive(); s_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      to_sample();
      chk("t2_asi_valid", aif.asi_valid, 1);
      chk("t2_asi_rs1_hold", aif.asi_rs1, 32'hCAFEBABE);
      chk("t2_asi_rs2_hold", aif.asi_rs2, 32'h01234567);
      chk("t2_s_ready_exec", s_ready, 0);
      chk("t2_m_valid_exec", m_valid, 0);
      to_drive();
    end
    for (int i = 0; i < 3; i++) begin
      to_sample();
      chk("t2_m_valid_stall", m_valid, 1);
      chk("t2_m_result_stall", m_result, 32'hCAFEBABE ^ 32'h01234567);
      chk("t2_s_ready_stall", s_ready, 0);
      to_drive();
    end
    m_ready = 1'b1;
    to_sample(); chk("t2_s_ready_retire", s_ready, 1);
    to_drive(); to_sample();
    chk("t2_m_valid_after", m_valid, 0);

    // 3. Back-to-back with m_ready high
    to_drive();
    stub_lat = 1;
    drive_op(5'd3, 32'hAAAA0000, 32'h0000BBBB, 2'd0, 5'd1, 1'b1);
    to_drive();
    drive_op(5'd4, 32'h11112222, 32'h33334444, 2'd2, 5'd2, 1'b1);
    to_sample();
    chk("t3_s_ready_exec", s_ready, 0);
    chk("t3_asi_rs1_a", aif.asi_rs1, 32'hAAAA0000);
    to_drive(); to_sample();
    chk("t3_m_valid_c2", m_valid, 1);
    chk("t3_s_ready_hold", s_ready, 1);
    to_drive(); s_valid = 1'b0;
    to_sample();
    chk("t3_m_valid_c3", m_valid, 0);
    chk("t3_asi_valid_c3", aif.asi_valid, 1);
    chk("t3_asi_rs1_b", aif.asi_rs1, 32'h11112222);
    to_drive(); to_sample();
    chk("t3_m_valid_c4", m_valid, 1);
    to_drive(); to_sample();
    chk("t3_m_valid_c5", m_valid, 0);

    // 4a. Flush in 2nd EXEC cycle
    to_drive();
    stub_lat = 4;
    drive_op(5'd9, 32'h55555555, 32'h0F0F0F0F, 2'd0, 5'd20, 1'b0);
    to_drive(); s_valid = 1'b0;
    to_sample(); chk("t4_asi_flush_c1", aif.asi_flush, 0);
    to_drive(); flush = 1'b1;
    to_sample();
    chk("t4_asi_flush_c2", aif.asi_flush, 1);
    chk("t4_asi_valid_c2", aif.asi_valid, 1);
    chk("t4_s_ready_flush", s_ready, 0);
    to_drive(); flush = 1'b0;
    to_sample();
    chk("t4_asi_valid_c3", aif.asi_valid, 0);
    chk("t4_m_valid_c3", m_valid, 0);
    chk("t4_s_ready_c3", s_ready, 1);
    to_drive(); to_sample();
    chk("t4_m_valid_c4", m_valid, 0);

    // 4b. Flush coincident with asi_ready
    to_drive();
    stub_lat = 2;
    drive_op(5'd10, 32'h0BADF00D, 32'h12121212, 2'd1, 5'd21, 1'b0);
    to_drive(); s_valid = 1'b0;
    to_drive(); flush = 1'b1;
    to_sample();
    chk("t4b_asi_ready", aif.asi_ready, 1);
    chk("t4b_asi_flush", aif.asi_flush, 1);
    to_drive(); flush = 1'b0;
    to_sample();
    chk("t4b_m_valid_c3", m_valid, 0);
    chk("t4b_asi_valid_c3", aif.asi_valid, 0);
    to_drive(); to_sample();
    chk("t4b_m_valid_c4", m_valid, 0);

    // 5. Timeout
    to_drive();
    stub_lat = 0;
    drive_op(5'd11, 32'hDEADBEEF, 32'h00000001, 2'd0, 5'd9, 1'b0);
    sb.push_back('{rd: 5'd9, res: '0, err: 1'b1});
    to_drive(); s_valid = 1'b0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      to_sample();
      chk("t5_asi_valid", aif.asi_valid, 1);
      chk("t5_asi_flush", aif.asi_flush, (k == MAX_WAIT));
      chk("t5_m_valid_exec", m_valid, 0);
      to_drive();
    end
    to_sample();
    chk("t5_m_valid", m_valid, 1);
    chk("t5_m_err", m_err, 1);
    chk("t5_m_result", m_result, 0);
    chk("t5_asi_flush_hold", aif.asi_flush, 0);
    to_drive(); to_sample();
    chk("t5_m_valid_after", m_valid, 0);

    // 6. Asynchronous reset mid-EXEC
    to_drive();
    stub_lat = 4;
    drive_op(5'd12, 32'h13579BDF, 32'h2468ACE0, 2'd2, 5'd17, 1'b0);
    to_drive(); s_valid = 1'b0;
    chk("t6_asi_valid_pre", aif.asi_valid, 1);
    #2 g_resetn = 1'b0;
    #1;
    chk("t6_asi_valid_rst", aif.asi_valid, 0);
    chk("t6_asi_flush_rst", aif.asi_flush, 0);
    chk("t6_m_valid_rst", m_valid, 0);
    chk("t6_m_err_rst", m_err, 0);
    #1 g_resetn = 1'b1;
    to_sample();
    chk("t6_s_ready_post", s_ready, 1);
    chk("t6_asi_valid_post", aif.asi_valid, 0);
    chk("t6_m_valid_post", m_valid, 0);
    to_drive();
    stub_lat = 1;
    drive_op(5'd13, 32'hFFFF0000, 32'h00FF00FF, 2'd0, 5'd31, 1'b1);
    to_drive(); s_valid = 1'b0;
    to_drive(); to_sample();
    chk("t6_m_valid_op", m_valid, 1);
    to_drive(); to_sample();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
